// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared types for the pipeline hazard controller.
//   - hz_state_e  : sequencer state (normal run, data-memory wait, timeout error)
//   - pipe_ctrl_t : the seven per-stage stall/flush bits, bundled so the
//                   decision logic can build a whole control word at once
//   - run_ctrl()  : control word for the redirect / load-use rules that apply
//                   whenever the pipeline is free to advance
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NONE = '0;

    // Freeze everything up to and including EX/MEM; MEM/WB receives a bubble
    // so the stalled memory instruction is not written back twice.
    localparam pipe_ctrl_t CTRL_MEM_STALL = '{
        pc_stall:     1'b1,
        if_id_stall:  1'b1,
        if_id_flush:  1'b0,
        id_ex_stall:  1'b1,
        id_ex_flush:  1'b0,
        ex_mem_stall: 1'b1,
        mem_wb_flush: 1'b1
    };

    // A redirect squashes both younger instructions, which also makes any
    // load-use dependence of the ID instruction irrelevant.
    function automatic pipe_ctrl_t run_ctrl(input logic redirect, input logic luh);
        pipe_ctrl_t c;
        c = CTRL_NONE;
        if (redirect) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (luh) begin
            c.pc_stall    = 1'b1;
            c.if_id_stall = 1'b1;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the stall/flush performance counters.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clears the count)
//     inc        : add one this cycle (ignored once the count is all-ones)
//     clr        : synchronous clear, takes priority over inc
//     cnt        : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Central stall/flush sequencer for the 5-stage core. Resolves load-use
//   dependences, EX-stage redirects and multi-cycle data-memory waits, and
//   keeps stall/flush performance counters plus a sticky memory-timeout flag.
//
//   Ports:
//     clk, rst_n                     clock, asynchronous active-low reset
//     ID_rs1_i/ID_rs2_i              source registers of the ID instruction
//     ID_uses_rs1_i/ID_uses_rs2_i    the ID instruction actually reads them
//     EX_rd_i, EX_MemRead_i          destination / load flag of the EX instruction
//     EX_redirect_i                  taken branch or jump resolved in EX
//     MEM_req_i, MEM_ready_i         data-memory access active / completing
//     pc_stall_o ... MEM_WB_flush_o  per-stage controls (combinational)
//     mem_timeout_o                  sticky: memory wait exceeded MEM_TIMEOUT
//     stall_cnt_o                    cycles with pc_stall_o high (saturating)
//     flush_cnt_o                    cycles with ID_EX_flush_o high (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] ID_rs1_i,
    input  logic [REG_ADDR_W-1:0] ID_rs2_i,
    input  logic                  ID_uses_rs1_i,
    input  logic                  ID_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] EX_rd_i,
    input  logic                  EX_MemRead_i,
    input  logic                  EX_redirect_i,
    input  logic                  MEM_req_i,
    input  logic                  MEM_ready_i,
    output logic                  pc_stall_o,
    output logic                  IF_ID_stall_o,
    output logic                  IF_ID_flush_o,
    output logic                  ID_EX_stall_o,
    output logic                  ID_EX_flush_o,
    output logic                  EX_MEM_stall_o,
    output logic                  MEM_WB_flush_o,
    output logic                  mem_timeout_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    hz_state_e         state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              timeout_nxt;
    logic              luh;
    logic              mem_wait;
    logic [WAIT_W-1:0] wait_inc;
    pipe_ctrl_t        ctrl;
    pipe_ctrl_t        ctrl_out;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign luh = EX_MemRead_i && (EX_rd_i != '0) &&
                 ((ID_uses_rs1_i && (ID_rs1_i == EX_rd_i)) ||
                  (ID_uses_rs2_i && (ID_rs2_i == EX_rd_i)));

    // A ready without a request is meaningless and is not treated as a wait.
    assign mem_wait = MEM_req_i && !MEM_ready_i;
    assign wait_inc = wait_cnt + WAIT_W'(1);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ctrl         = CTRL_NONE;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = mem_timeout_o;

        case (state)
            S_RUN: begin
                if (mem_wait) begin
                    // The cycle that discovers the wait is the first wait cycle.
                    ctrl         = CTRL_MEM_STALL;
                    wait_cnt_nxt = WAIT_W'(1);
                    state_nxt    = S_MEM_WAIT;
                end else begin
                    ctrl = run_ctrl(EX_redirect_i, luh);
                end
            end

            S_MEM_WAIT: begin
                if (MEM_ready_i) begin
                    // Release cycle: EX/ID were frozen, so their hazards are
                    // evaluated now with the normal run rules.
                    ctrl         = run_ctrl(EX_redirect_i, luh);
                    wait_cnt_nxt = '0;
                    state_nxt    = S_RUN;
                end else begin
                    ctrl         = CTRL_MEM_STALL;
                    wait_cnt_nxt = wait_inc;
                    if (wait_inc >= WAIT_LIMIT) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = S_ERR;
                    end
                end
            end

            S_ERR: begin
                ctrl = CTRL_MEM_STALL;
            end

            default: begin
                ctrl      = CTRL_MEM_STALL;
                state_nxt = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RUN;
            wait_cnt      <= '0;
            mem_timeout_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            mem_timeout_o <= timeout_nxt;
        end
    end

    // Controls are forced low for the whole reset window, not just after the
    // state flops clear, so a reset between edges silences them immediately.
    assign ctrl_out = rst_n ? ctrl : CTRL_NONE;

    assign pc_stall_o     = ctrl_out.pc_stall;
    assign IF_ID_stall_o  = ctrl_out.if_id_stall;
    assign IF_ID_flush_o  = ctrl_out.if_id_flush;
    assign ID_EX_stall_o  = ctrl_out.id_ex_stall;
    assign ID_EX_flush_o  = ctrl_out.id_ex_flush;
    assign EX_MEM_stall_o = ctrl_out.ex_mem_stall;
    assign MEM_WB_flush_o = ctrl_out.mem_wb_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl_out.pc_stall),
        .clr   (1'b0),
        .cnt   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl_out.id_ex_flush),
        .clr   (1'b0),
        .cnt   (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl: directed scenarios followed by
//   randomized traffic, all compared against a behavioural reference model.
//   Control vector order: {pc, IF_ID stall, IF_ID flush, ID_EX stall,
//   ID_EX flush, EX_MEM stall, MEM_WB flush}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int RW      = 5;
    localparam int TIMEOUT = 4;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_STALL = 7'b1101011;
    localparam logic [6:0] C_REDIR = 7'b0010100;
    localparam logic [6:0] C_LUH   = 7'b1100100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] ID_rs1_i = '0, ID_rs2_i = '0, EX_rd_i = '0;
    logic          ID_uses_rs1_i = 1'b0, ID_uses_rs2_i = 1'b0;
    logic          EX_MemRead_i = 1'b0, EX_redirect_i = 1'b0;
    logic          MEM_req_i = 1'b0, MEM_ready_i = 1'b0;
    logic          pc_stall_o, IF_ID_stall_o, IF_ID_flush_o, ID_EX_stall_o;
    logic          ID_EX_flush_o, EX_MEM_stall_o, MEM_WB_flush_o, mem_timeout_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;
    logic [6:0]    dut_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_waiting;
    bit m_err;
    int m_wait_cycles;
    int m_stall_cnt;
    int m_flush_cnt;

    hazard_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ID_rs1_i       (ID_rs1_i),
        .ID_rs2_i       (ID_rs2_i),
        .ID_uses_rs1_i  (ID_uses_rs1_i),
        .ID_uses_rs2_i  (ID_uses_rs2_i),
        .EX_rd_i        (EX_rd_i),
        .EX_MemRead_i   (EX_MemRead_i),
        .EX_redirect_i  (EX_redirect_i),
        .MEM_req_i      (MEM_req_i),
        .MEM_ready_i    (MEM_ready_i),
        .pc_stall_o     (pc_stall_o),
        .IF_ID_stall_o  (IF_ID_stall_o),
        .IF_ID_flush_o  (IF_ID_flush_o),
        .ID_EX_stall_o  (ID_EX_stall_o),
        .ID_EX_flush_o  (ID_EX_flush_o),
        .EX_MEM_stall_o (EX_MEM_stall_o),
        .MEM_WB_flush_o (MEM_WB_flush_o),
        .mem_timeout_o  (mem_timeout_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    assign dut_ctrl = {pc_stall_o, IF_ID_stall_o, IF_ID_flush_o, ID_EX_stall_o,
                       ID_EX_flush_o, EX_MEM_stall_o, MEM_WB_flush_o};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_waiting     = 1'b0;
        m_err         = 1'b0;
        m_wait_cycles = 0;
        m_stall_cnt   = 0;
        m_flush_cnt   = 0;
    endfunction

    function automatic logic [6:0] model_ctrl();
        bit luh;
        luh = EX_MemRead_i && (EX_rd_i != 0) &&
              ((ID_uses_rs1_i && ID_rs1_i == EX_rd_i) ||
               (ID_uses_rs2_i && ID_rs2_i == EX_rd_i));
        if (!rst_n)                                 return C_NONE;
        if (m_err)                                  return C_STALL;
        if (m_waiting && !MEM_ready_i)              return C_STALL;
        if (!m_waiting && MEM_req_i && !MEM_ready_i) return C_STALL;
        if (EX_redirect_i)                          return C_REDIR;
        if (luh)                                    return C_LUH;
        return C_NONE;
    endfunction

    // Advance the model across one rising edge, given the controls it predicted.
    function automatic void model_edge(input logic [6:0] c);
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (c[6] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (c[2] && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        if (m_err) begin
            // stays in error until reset
        end else if (m_waiting) begin
            if (MEM_ready_i) begin
                m_waiting = 1'b0;
            end else begin
                m_wait_cycles++;
                if (m_wait_cycles >= TIMEOUT) begin
                    m_err     = 1'b1;
                    m_waiting = 1'b0;
                end
            end
        end else if (MEM_req_i && !MEM_ready_i) begin
            m_waiting     = 1'b1;
            m_wait_cycles = 1;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic req, input logic rdy, input logic redir,
                         input logic mrd, input logic [RW-1:0] rd,
                         input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic u1, input logic u2);
        MEM_req_i     = req;
        MEM_ready_i   = rdy;
        EX_redirect_i = redir;
        EX_MemRead_i  = mrd;
        EX_rd_i       = rd;
        ID_rs1_i      = rs1;
        ID_rs2_i      = rs2;
        ID_uses_rs1_i = u1;
        ID_uses_rs2_i = u2;
    endtask

    // Called at posedge+1: sample mid-cycle, compare, then cross one edge.
    task automatic step(input bit has_want, input logic [6:0] want);
        logic [6:0] e;
        #3;
        e = model_ctrl();
        check("ctrl", 32'(dut_ctrl), 32'(e));
        if (has_want) check("dir_ctrl", 32'(dut_ctrl), 32'(want));
        check("stall_cnt", 32'(stall_cnt_o), 32'(m_stall_cnt));
        check("flush_cnt", 32'(flush_cnt_o), 32'(m_flush_cnt));
        check("timeout", 32'(mem_timeout_o), 32'(m_err));
        @(posedge clk);
        model_edge(e);
        #1;
    endtask

    // Asserts reset with hazard-producing inputs still applied, then releases
    // it just after a rising edge so the bench resumes at posedge+1.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_ctrl", 32'(dut_ctrl), 32'(C_NONE));
        check("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
        check("rst_timeout", 32'(mem_timeout_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        drive(1, 0, 0, 1, 5, 5, 0, 1, 0);
        apply_reset();

        // Load-use on rs1
        drive(0, 0, 0, 1, 5, 5, 0, 1, 0);
        step(1, C_LUH);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
        check("lu_flush_cnt", 32'(flush_cnt_o), 32'd1);
        // Load-use on rs2
        drive(0, 0, 0, 1, 7, 1, 7, 0, 1);
        step(1, C_LUH);
        // Load into x0: no hazard
        drive(0, 0, 0, 1, 0, 0, 0, 1, 1);
        step(1, C_NONE);
        // Matching register but operand not used: no hazard
        drive(0, 0, 0, 1, 9, 9, 9, 0, 0);
        step(1, C_NONE);
        // Redirect coincident with load-use: redirect wins
        drive(0, 0, 1, 1, 5, 5, 0, 1, 0);
        step(1, C_REDIR);
        // Single-cycle memory access and stray ready: no stall
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, C_NONE);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, C_NONE);

        // Memory wait of 3 cycles then ready
        apply_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, C_STALL);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, C_NONE);
        check("wait_stall_cnt", 32'(stall_cnt_o), 32'd3);

        // Redirect held throughout a wait: flushes only on the ready cycle
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, C_STALL);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, C_REDIR);
        // Load-use pending across a wait, acted on at release
        drive(1, 0, 0, 1, 3, 3, 0, 1, 0);
        repeat (2) step(1, C_STALL);
        drive(1, 1, 0, 1, 3, 3, 0, 1, 0);
        step(1, C_LUH);

        // Timeout: never ready
        apply_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, C_NONE);
        check("timeout_early", 32'(mem_timeout_o), 32'd0);
        step(0, C_NONE);
        check("timeout_set", 32'(mem_timeout_o), 32'd1);
        // Error state holds stalls whatever the inputs; stall counter saturates
        drive(1, 1, 1, 1, 5, 5, 5, 1, 1);
        repeat (300) step(1, C_STALL);
        check("stall_sat", 32'(stall_cnt_o), 32'(CNT_MAX));
        apply_reset();

        // Asynchronous reset between edges during a wait
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, C_STALL);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ctrl", 32'(dut_ctrl), 32'(C_NONE));
        check("async_stall_cnt", 32'(stall_cnt_o), 32'd0);
        check("async_timeout", 32'(mem_timeout_o), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, C_NONE);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic req, rdy;
            if ($urandom_range(0, 299) == 0 || (m_err && $urandom_range(0, 7) == 0)) begin
                apply_reset();
            end
            if (m_waiting) begin
                req = 1'b1;
                rdy = ($urandom_range(0, 2) == 0);
            end else begin
                req = ($urandom_range(0, 3) == 0);
                rdy = $urandom_range(0, 1) != 0;
            end
            drive(req, rdy, $urandom_range(0, 4) == 0, $urandom_range(0, 1) != 0,
                  RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                  RW'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 1) != 0);
            step(0, C_NONE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Generates per-stage stall/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazard classes: load-use dependences, taken-branch/jump redirects from EX, and multi-cycle data-memory waits.
- Keeps stall/flush performance counters and a sticky memory-timeout error.

Parameters:
- REG_ADDR_W, 5, register-index width.
- MEM_TIMEOUT, 64, maximum consecutive wait cycles before the timeout error (≥2).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- ID_rs1_i  in  REG_ADDR_W  rs1 index of the instruction in ID
- ID_rs2_i  in  REG_ADDR_W  rs2 index of the instruction in ID
- ID_uses_rs1_i  in  1  the ID instruction reads rs1
- ID_uses_rs2_i  in  1  the ID instruction reads rs2
- EX_rd_i  in  REG_ADDR_W  destination of the instruction in EX
- EX_MemRead_i  in  1  the EX instruction is a load
- EX_redirect_i  in  1  taken branch/jump resolved in EX
- MEM_req_i  in  1  data-memory access active in MEM
- MEM_ready_i  in  1  data memory completes the access this cycle
- pc_stall_o  out  1  hold PC
- IF_ID_stall_o  out  1  hold IF/ID
- IF_ID_flush_o  out  1  zero IF/ID
- ID_EX_stall_o  out  1  hold ID/EX
- ID_EX_flush_o  out  1  load bubble into ID/EX (drives flush_i)
- EX_MEM_stall_o  out  1  hold EX/MEM
- MEM_WB_flush_o  out  1  bubble into MEM/WB
- mem_timeout_o  out  1  sticky timeout error
- stall_cnt_o  out  CNT_W  cycles with pc_stall_o high
- flush_cnt_o  out  CNT_W  cycles with ID_EX_flush_o high

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0: state=S_RUN, both counters=0, mem_timeout_o=0, and every stall/flush output is forced to 0 regardless of inputs.
- Stall/flush outputs are combinational from the current state and inputs, taking effect in the same cycle. Counters and the error flag are registered.
- Load-use hazard: luh = EX_MemRead_i && EX_rd_i!=0 && ((ID_uses_rs1_i && ID_rs1_i==EX_rd_i) || (ID_uses_rs2_i && ID_rs2_i==EX_rd_i)).
- States: S_RUN, S_MEM_WAIT, S_ERR.
- Priority order: memory wait > redirect > load-use.
- S_RUN:
  - Memory wait (MEM_req_i && !MEM_ready_i): assert pc/IF_ID/ID_EX/EX_MEM stall and MEM_WB_flush. Load wait counter with 1. Go to S_MEM_WAIT.
  - Otherwise, EX_redirect_i: assert IF_ID_flush and ID_EX_flush. Load-use is ignored because the ID instruction is squashed.
  - Otherwise, luh: assert pc_stall, IF_ID_stall and ID_EX_flush for exactly one cycle. No state change; luh clears naturally once the bubble reaches EX.
- S_MEM_WAIT:
  - Same stall set as above each cycle; wait counter increments.
  - EX_redirect_i and luh are ignored, since EX and ID are frozen and re-evaluated after release.
  - MEM_ready_i=1: deassert all stalls that cycle and return to S_RUN. A redirect/luh present that cycle is acted on in the same cycle using the S_RUN rules.
  - Counter reaching MEM_TIMEOUT with !MEM_ready_i: set mem_timeout_o and go to S_ERR.
- S_ERR:
  - pc_stall, IF_ID_stall, ID_EX_stall and EX_MEM_stall are held high; MEM_WB_flush is high.
  - Exit only via reset.
- MEM_ready_i=1 in S_RUN with MEM_req_i=1 is a single-cycle access and causes no stall.
- MEM_ready_i without MEM_req_i is ignored.
- Counters saturate at all-ones (no wrap). Each increments by 1 per qualifying cycle.
- Wait counter width is $clog2(MEM_TIMEOUT+1).
- Reset asserted mid-wait aborts immediately to S_RUN with all outputs at 0.

Decomposition:
- Shared package: hz_state_e (S_RUN, S_MEM_WAIT, S_ERR) plus a packed pipe_ctrl_t struct bundling the seven stall/flush bits, for the top level to fan out.
- One natural sub-module, sat_counter (parameter W, inputs inc/clr, saturating), instantiated for stall_cnt and flush_cnt.

Test Plan:
- Load-use: EX_MemRead_i=1, EX_rd_i=5, ID_rs1_i=5, ID_uses_rs1_i=1 for one cycle -> pc_stall, IF_ID_stall, ID_EX_flush =1 that cycle; stall_cnt_o=1, flush_cnt_o=1 next cycle. With EX_rd_i=0 -> no stall.
- Redirect coincident with luh: EX_redirect_i=1 and luh=1 -> IF_ID_flush=ID_EX_flush=1, pc_stall=0.
- Memory wait: MEM_req_i=1, MEM_ready_i=0 for 3 cycles then 1 -> four stall outputs and MEM_WB_flush high for 3 cycles, all low on the ready cycle; stall_cnt_o=3.
- Redirect during wait: EX_redirect_i=1 held throughout the wait -> no flush during stall cycles; IF_ID_flush/ID_EX_flush high exactly on the ready cycle.
- Timeout: MEM_TIMEOUT=4, MEM_req_i=1, MEM_ready_i=0 forever -> mem_timeout_o=1 after the 4th wait cycle; stalls held; then rst_n pulse -> all outputs 0 and counters 0.
- Async reset mid-wait: drop rst_n between clock edges during S_MEM_WAIT -> outputs go to 0 immediately, without waiting for a clock edge.
